// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and byte-packing geometry.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_LOAD  = 3'd1;
  localparam logic [2:0] ENC_WRITE = 3'd2;
  localparam logic [2:0] ENC_CHECK = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;
  localparam logic [2:0] ENC_ERROR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_LOAD  = ENC_LOAD,
    ST_WRITE = ENC_WRITE,
    ST_CHECK = ENC_CHECK,
    ST_DONE  = ENC_DONE,
    ST_ERROR = ENC_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: the k-th accepted byte lands in bits [8k+7:8k]; word_ready
// pulses combinationally in the cycle the final byte of a word is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [31:0]       word_q, word_d;

  // Byte index advance and byte insertion into the word register.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept) begin
      idx_d                       = idx_q + BIDX_W'(1);
      word_d[{idx_q, 3'b000} +: 8] = byte_in;
    end else begin
      idx_d  = idx_q;
    end
  end

  // Packer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word       = word_q;
  assign word_ready = accept && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-RAM loader: streams bytes into sequential words and holds the core in
// reset until the requested word count is written. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e END_ST = ST_CHECK;
`else
  localparam state_e END_ST = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d, words_q, words_d, clamp_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              byte_ready_q, byte_ready_d, mem_we_q, mem_we_d;
  logic              core_rst_q, core_rst_d, busy_q, busy_d, done_q, done_d;
  logic              accept, pk_accept, pk_clear, pk_word_ready, can_start;
  logic [31:0]       pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .accept     (pk_accept),
    .byte_in    (byte_data),
    .word       (pk_word),
    .word_ready (pk_word_ready)
  );

  // Next-state, address/count updates and registered-output decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    addr_d    = addr_q;
    pk_clear  = 1'b0;
    accept    = byte_ready_q && byte_valid;
    pk_accept = accept && (state_q == ST_LOAD);
    clamp_s   = (num_words > DEPTH_C) ? DEPTH_C : num_words;
    can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
    can_start = can_start || (state_q == ST_ERROR);
    if (pk_accept) sum_d = sum_q + byte_data;
    else           sum_d = sum_q;
`endif
    if (can_start) begin
      if (start) begin
        count_d  = clamp_s;
        words_d  = '0;
        addr_d   = '0;
        pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = 8'h00;
`endif
        state_d  = (clamp_s == '0) ? END_ST : ST_LOAD;
      end else begin
        state_d  = state_q;
      end
    end else begin
      case (state_q)
        ST_LOAD:  state_d = pk_word_ready ? ST_WRITE : ST_LOAD;
        ST_WRITE: begin
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_q + ONE_C;
          state_d = (words_d == count_q) ? END_ST : ST_LOAD;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) state_d = (byte_data == sum_q) ? ST_DONE : ST_ERROR;
          else        state_d = ST_CHECK;
        end
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
    byte_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
    mem_we_d     = (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    core_rst_d   = (state_d != ST_DONE);
`ifdef LOADER_CHECKSUM_EN
    err_d        = (state_d == ST_ERROR);
`endif
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= 8'h00;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      core_rst_q   <= core_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = pk_word;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign words_loaded = words_q;
`ifdef LOADER_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of single-word loads plus directed multi-cycle sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_words = 6'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, core_rst, busy, done, err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  words_loaded;

  int n_chk = 0;
  int n_err = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // write monitor, sampled mid-cycle
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          bad_ready = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (byte_ready) bad_ready++;
    end
  end

  logic [7:0] stream[$];

  typedef struct {
    logic [5:0]  nw;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] nw);
    start = 1'b1; num_words = nw; tick(); start = 1'b0;
  endtask

  // drive every byte in 'stream'; returns one cycle after the last accepting edge
  task automatic send_stream(input bit gaps);
    for (int i = 0; i < stream.size(); i++) begin
      int n = 0;
      if (gaps) begin byte_valid = 1'b0; tick(); end
      byte_valid = 1'b1;
      byte_data  = stream[i];
      while (!byte_ready && n < 50) begin tick(); n++; end
      if (!byte_ready) begin
        chk("byte_ready_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
        return;
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk(nm, done, 1'b1);
  endtask

  // send the trailing checksum byte when the checksum stage is built in
  task automatic send_sum(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
    stream = {s};
    send_stream(1'b0);
`else
    if (s === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic two_word_stream();
    stream = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
  endtask

  initial begin
    logic [7:0]  s;
    logic [31:0] w;
    int          bad, base;

    vecs[0] = '{6'd1, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
    vecs[1] = '{6'd1, 8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
    vecs[2] = '{6'd1, 8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000};
    vecs[3] = '{6'd1, 8'h01, 8'h00, 8'h00, 8'h00, 32'h00000001};

    // reset values
    do_reset();
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 37'd0);
    chk("rst_busy_done_err", {busy, done, err}, 3'b000);
    chk("rst_words", words_loaded, 6'd0);

    // two-word load, valid held high, with an ignored start while busy
    do_start(6'd2);
    chk("load_busy_ready", {busy, byte_ready, core_rst}, 3'b111);
    do_start(6'd5);
    two_word_stream();
    send_stream(1'b0);
`ifndef LOADER_CHECKSUM_EN
    chk("lat_we", {mem_we, byte_ready, done}, 3'b100);
    chk("lat_we_addr", mem_addr, 5'd1);
    chk("lat_we_data", mem_wdata, 32'h00500093);
    tick();
    chk("lat_done", {done, core_rst, busy}, 3'b100);
`else
    send_sum(8'hF6);
    tick();
    chk("sum_ok_done", {done, core_rst, err}, 3'b100);
`endif
    chk("two_words_loaded", words_loaded, 6'd2);
    chk("two_wr_count", wr_addr.size(), 2);
    chk("two_wr0", {wr_addr[0], wr_data[0]}, {5'd0, 32'h00000013});
    chk("two_wr1", {wr_addr[1], wr_data[1]}, {5'd1, 32'h00500093});

`ifdef LOADER_CHECKSUM_EN
    // checksum mismatch, then recovery via start from ERROR
    do_start(6'd2);
    two_word_stream();
    send_stream(1'b0);
    send_sum(8'hF7);
    tick();
    chk("sum_bad_err", {err, core_rst, done, busy}, 4'b1100);
    do_start(6'd0);
    send_sum(8'h00);
    tick();
    chk("sum_restart", {err, done, core_rst}, 3'b010);
`endif

    // stalled stream
    do_reset();
    wr_addr.delete(); wr_data.delete(); bad_ready = 0;
    do_start(6'd2);
    two_word_stream();
    send_stream(1'b1);
    send_sum(8'hF6);
    wait_done("stall_done");
    chk("stall_wr_count", wr_addr.size(), 2);
    chk("stall_wr0", {wr_addr[0], wr_data[0]}, {5'd0, 32'h00000013});
    chk("stall_wr1", {wr_addr[1], wr_data[1]}, {5'd1, 32'h00500093});
    chk("stall_ready_in_write", bad_ready, 0);

    // zero words
    do_reset();
    wr_addr.delete(); wr_data.delete();
    do_start(6'd0);
`ifdef LOADER_CHECKSUM_EN
    send_sum(8'h00);
`endif
    chk("zero_done", {done, core_rst}, 2'b10);
    chk("zero_no_write", wr_addr.size(), 0);

    // clamp 40 -> 32
    do_reset();
    wr_addr.delete(); wr_data.delete();
    stream.delete();
    s = 8'h00;
    for (int i = 0; i < 128; i++) begin
      stream.push_back(8'(i * 7 + 3));
      s = s + 8'(i * 7 + 3);
    end
    do_start(6'd40);
    send_stream(1'b0);
    send_sum(s);
    wait_done("clamp_done");
    chk("clamp_wr_count", wr_addr.size(), 32);
    chk("clamp_words", words_loaded, 6'd32);
    bad = 0;
    for (int k = 0; k < 32 && k < wr_addr.size(); k++) begin
      w = {8'(4*k*7 + 24), 8'(4*k*7 + 17), 8'(4*k*7 + 10), 8'(4*k*7 + 3)};
      if (wr_addr[k] !== 5'(k) || wr_data[k] !== w) bad++;
    end
    chk("clamp_contents", bad, 0);

    // reset mid-load after 6 bytes
    do_reset();
    wr_addr.delete(); wr_data.delete();
    do_start(6'd2);
    stream = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_vals", {mem_we, core_rst, busy, done, byte_ready}, 5'b01000);
    chk("midrst_words_addr", {words_loaded, mem_addr}, 11'd0);
    base = wr_addr.size();
    for (int i = 0; i < 8; i++) tick();
    chk("midrst_no_more_we", wr_addr.size(), base);
    do_start(6'd1);
    stream = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(1'b0);
    send_sum(8'h0E);
    wait_done("midrst_reload_done");
    chk("midrst_reload_wr", {wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]},
        {5'd0, 32'hDDCCBBAA});

    // restart from DONE
    do_start(6'd1);
    chk("restart_core_rst", {core_rst, busy, done}, 3'b110);
    stream = {8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(1'b0);
    send_sum(8'h0A);
    wait_done("restart_done");
    chk("restart_wr", {wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]},
        {5'd0, 32'h04030201});

    // table of single-word loads, each restarted from DONE
    for (int v = 0; v < 4; v++) begin
      base = wr_addr.size();
      do_start(vecs[v].nw);
      stream = {vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
      send_stream(1'b0);
      send_sum(vecs[v].b0 + vecs[v].b1 + vecs[v].b2 + vecs[v].b3);
      wait_done("vec_done");
      chk("vec_wr_count", wr_addr.size() - base, 1);
      if (wr_addr.size() > base)
        chk("vec_word", {wr_addr[base], wr_data[base]}, {5'd0, vecs[v].exp_word});
      chk("vec_words_loaded", words_loaded, 6'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
